shift_sequencer: RTL and testbench
==================================

// Module: shift_sequencer
// PURPOSE
//  Multi-bit shift controller for the single-step shifters (RShifter, LShifter, 1 bit/clock, output registered).
//  Accepts {data, amount, direction} on a valid/ready request port and selects the right or left shifter.
//  Steps that shifter 'amount' clocks by feeding its output back to its input, then returns the result on a
//  valid/ready response port. Sits between the ALU decode stage and the shifters; the two shifters share one sequencer.
// PARAMETERS
//  n   4               data width; must equal the n of both attached shifters
//  AW  $clog2(n)+1     request amount width; must be able to represent n
// PORTS
//  clock      in   1   system clock, rising edge
//  reset      in   1   asynchronous, active-high
//  req_valid  in   1   request present
//  req_ready  out  1   sequencer can accept a request (IDLE only)
//  req_data   in   n   operand
//  req_amt    in   AW  shift distance, unsigned
//  req_dir    in   1   0 = logical right, 1 = logical left
//  rsp_valid  out  1   result available
//  rsp_ready  in   1   consumer takes result
//  rsp_data   out  n   shifted result; defined only while rsp_valid=1
//  busy       out  1   high in SHIFT or DONE
//  sr_en/sl_en  out 1  step enable, right/left shifter
//  sr_in/sl_in  out n  operand to the right/left shifter
//  sr_out/sl_out in n  registered shifter output; shifter holds its output while en=0
// BEHAVIOUR
//  Reset (async): state=IDLE, cnt=0, sr_en=sl_en=0, rsp_valid=0, busy=0, req_ready=1; data_q, dir_q, byp_q cleared.
//   Shifter contents are not cleared.
//  States: IDLE -> SHIFT -> DONE -> IDLE, or IDLE -> DONE when amount is 0.
//  IDLE: req_ready=1. On req_valid, latch data_q=req_data, dir_q=req_dir, amt=min(req_amt,n).
//   amt==0: byp_q=1, go DONE. Otherwise byp_q=0, cnt=amt, first=1, go SHIFT.
//  SHIFT: the selected en (dir_q) is 1 and the other en is 0.
//   Selected *_in = first ? data_q : selected *_out; first clears after the first cycle.
//   The unselected *_in is driven with data_q. cnt decrements each clock; on cnt==1 go DONE.
//  DONE: rsp_valid=1, both en=0. rsp_data = byp_q ? data_q : (dir_q ? sl_out : sr_out), a combinational mux.
//   rsp_data holds stable while rsp_ready=0. On rsp_ready go IDLE.
//  Latency, accept edge to rsp_valid: amt k>=1 gives k+1 clocks; amt 0 gives 1 clock. Throughput is one op per k+2 clocks.
//  Clamp: req_amt>n behaves as n, so the result is all zeros after n steps.
//  req_valid while busy is ignored (req_ready=0); the requester must hold it.
//  Reset asserted in SHIFT or DONE aborts the operation: no rsp_valid, en drops immediately.
//  req_dir/req_data changes after acceptance do not affect the operation in flight.
// STRUCTURE
//  Shared include shift_defs.vh: state encodings ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2; DIR_RIGHT=0, DIR_LEFT=1.
//  Single flat module (FSM + down-counter + input/output muxes). Shifters are instantiated by the parent, not here.
//  Unreachable state encoding 2'd3 returns to ST_IDLE.
// TESTING  (n=4, bench instantiates RShifter + LShifter, rsp_ready=1 unless stated)
//  1. req 1010, amt 1, dir R -> sr_en high 1 clock; rsp_data=0101 at accept+2; sl_en never high.
//  2. req 1011, amt 3, dir L -> sl_en high 3 clocks; rsp_data=1000 at accept+4.
//  3. req 1010, amt 0, dir R -> no en pulse; rsp_valid at accept+1; rsp_data=1010.
//  4. req 1111, amt 7, dir R -> clamped to 4 steps; rsp_data=0000 at accept+5.
//  5. rsp_ready=0 for 5 clocks in DONE -> rsp_valid and rsp_data=0010 held (req 1010, amt 2, R); a new req_valid is not accepted.
//  6. reset pulse mid-SHIFT (amt 3, after 1 step) -> en=0 and IDLE asynchronously; no rsp_valid; next req completes correctly.

Source files
------------

// File: rtl/shift_sequencer_pkg.sv
// Shared state encodings and direction codes for the shift sequencer and its attached shifters.
package shift_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/response handshake bundle between the ALU decode stage (master) and the shift sequencer (slave).
interface shift_sequencer_if #(
  parameter int n  = 4,
  parameter int AW = $clog2(n) + 1
);
  logic          req_valid;
  logic          req_ready;
  logic [n-1:0]  req_data;
  logic [AW-1:0] req_amt;
  logic          req_dir;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [n-1:0]  rsp_data;

  modport master (
    output req_valid, req_data, req_amt, req_dir, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_data, req_amt, req_dir, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/shift_sequencer_stepper.sv
// Single-step logical shifter, one bit per enabled clock, registered output held while en=0.
// LEFT selects direction; contents are deliberately not reset.
module shift_sequencer_stepper #(
  parameter int n    = 4,
  parameter bit LEFT = 1'b0
) (
  input  logic         clock,
  input  logic         en,
  input  logic [n-1:0] d,
  output logic [n-1:0] q
);

  always_ff @(posedge clock) begin
    if (en) begin
      q <= LEFT ? (d << 1) : (d >> 1);
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Steps a shared right/left single-step shifter 'amount' clocks; response k+1 clocks after accept (1 for amount 0).
// One op in flight: req_ready only in IDLE; result held in DONE until rsp_ready.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int n  = 4,
  parameter int AW = $clog2(n) + 1
) (
  input  logic         clock,
  input  logic         reset,
  shift_sequencer_if.slave bus,
  output logic         busy,
  output logic         sr_en,
  output logic         sl_en,
  output logic [n-1:0] sr_in,
  output logic [n-1:0] sl_in,
  input  logic [n-1:0] sr_out,
  input  logic [n-1:0] sl_out
);

  state_t        state, state_nxt;
  logic [AW-1:0] cnt;
  logic [AW-1:0] amt_clamped;
  logic [n-1:0]  data_q;
  logic          dir_q;
  logic          byp_q;
  logic          first_q;
  logic          accept;

  assign amt_clamped = (bus.req_amt > AW'(n)) ? AW'(n) : bus.req_amt;
  assign accept      = (state == ST_IDLE) && bus.req_valid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      data_q  <= '0;
      dir_q   <= DIR_RIGHT;
      byp_q   <= 1'b0;
      first_q <= 1'b0;
    end else if (accept) begin
      data_q  <= bus.req_data;
      dir_q   <= bus.req_dir;
      byp_q   <= (amt_clamped == '0);
      cnt     <= amt_clamped;
      first_q <= (amt_clamped != '0);
    end else if (state == ST_SHIFT) begin
      cnt     <= cnt - AW'(1);
      first_q <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          state_nxt = (amt_clamped == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt == AW'(1)) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.rsp_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The unselected shifter sees data_q so its input never floats between ops.
  always_comb begin
    bus.req_ready = (state == ST_IDLE);
    bus.rsp_valid = (state == ST_DONE);
    busy          = (state == ST_SHIFT) || (state == ST_DONE);
    sr_en         = (state == ST_SHIFT) && (dir_q == DIR_RIGHT);
    sl_en         = (state == ST_SHIFT) && (dir_q == DIR_LEFT);
    sr_in         = (sr_en && !first_q) ? sr_out : data_q;
    sl_in         = (sl_en && !first_q) ? sl_out : data_q;
    if (byp_q) begin
      bus.rsp_data = data_q;
    end else if (dir_q == DIR_LEFT) begin
      bus.rsp_data = sl_out;
    end else begin
      bus.rsp_data = sr_out;
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer driving real right/left steppers; expected results computed by hand.
module tb_shift_sequencer;

  localparam int N  = 4;
  localparam int AW = 3;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         busy, sr_en, sl_en;
  logic [N-1:0] sr_in, sl_in, sr_out, sl_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  shift_sequencer_if #(.n(N), .AW(AW)) bus ();

  shift_sequencer #(.n(N), .AW(AW)) dut (
    .clock  (clock),
    .reset  (reset),
    .bus    (bus),
    .busy   (busy),
    .sr_en  (sr_en),
    .sl_en  (sl_en),
    .sr_in  (sr_in),
    .sl_in  (sl_in),
    .sr_out (sr_out),
    .sl_out (sl_out)
  );

  shift_sequencer_stepper #(.n(N), .LEFT(1'b0)) u_rsh (
    .clock (clock), .en (sr_en), .d (sr_in), .q (sr_out)
  );

  shift_sequencer_stepper #(.n(N), .LEFT(1'b1)) u_lsh (
    .clock (clock), .en (sl_en), .d (sl_in), .q (sl_out)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one request, count enable pulses until rsp_valid, optionally stall the response.
  task automatic run_op(input string tag, input logic [N-1:0] data, input logic [AW-1:0] amt,
                        input logic dir, input logic [N-1:0] exp_data, input int exp_lat,
                        input int exp_sr, input int exp_sl, input int hold);
    int lat;
    int nsr;
    int nsl;
    bus.rsp_ready = (hold == 0);
    bus.req_data  = data;
    bus.req_amt   = amt;
    bus.req_dir   = dir;
    bus.req_valid = 1'b1;
    check_eq({tag, "/req_ready"}, 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
    bus.req_data  = ~data;
    bus.req_dir   = ~dir;
    bus.req_amt   = '0;
    lat = 1;
    nsr = 0;
    nsl = 0;
    while (!bus.rsp_valid && lat < 40) begin
      nsr += int'(sr_en);
      nsl += int'(sl_en);
      tick();
      lat++;
    end
    check_eq({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "/sr_pulses"}, 32'(nsr), 32'(exp_sr));
    check_eq({tag, "/sl_pulses"}, 32'(nsl), 32'(exp_sl));
    check_eq({tag, "/rsp_data"}, 32'(bus.rsp_data), 32'(exp_data));
    for (int i = 0; i < hold; i++) begin
      bus.req_valid = 1'b1;
      bus.req_data  = 4'b1111;
      bus.req_amt   = 3'd1;
      check_eq({tag, "/hold_valid"}, 32'(bus.rsp_valid), 32'd1);
      check_eq({tag, "/hold_data"}, 32'(bus.rsp_data), 32'(exp_data));
      check_eq({tag, "/hold_ready"}, 32'(bus.req_ready), 32'd0);
      tick();
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    check_eq({tag, "/idle_valid"}, 32'(bus.rsp_valid), 32'd0);
    check_eq({tag, "/idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic saw_valid;
    bus.req_valid = 1'b0;
    bus.req_data  = '0;
    bus.req_amt   = '0;
    bus.req_dir   = 1'b0;
    bus.rsp_ready = 1'b1;

    #12;
    check_eq("rst/req_ready", 32'(bus.req_ready), 32'd1);
    check_eq("rst/rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rst/busy", 32'(busy), 32'd0);
    check_eq("rst/en", 32'({sr_en, sl_en}), 32'd0);
    reset = 1'b0;
    tick();

    run_op("r1",    4'b1010, 3'd1, 1'b0, 4'b0101, 2, 1, 0, 0);
    run_op("l3",    4'b1011, 3'd3, 1'b1, 4'b1000, 4, 0, 3, 0);
    run_op("byp",   4'b1010, 3'd0, 1'b0, 4'b1010, 1, 0, 0, 0);
    run_op("clamp", 4'b1111, 3'd7, 1'b0, 4'b0000, 5, 4, 0, 0);
    run_op("l4",    4'b1001, 3'd4, 1'b1, 4'b0000, 5, 0, 4, 0);
    run_op("r2",    4'b1100, 3'd2, 1'b0, 4'b0011, 3, 2, 0, 0);
    run_op("stall", 4'b1010, 3'd2, 1'b0, 4'b0010, 3, 2, 0, 5);

    // Abort a 3-step right shift after its first step.
    bus.req_data  = 4'b1010;
    bus.req_amt   = 3'd3;
    bus.req_dir   = 1'b0;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    tick();
    check_eq("abort/pre_en", 32'(sr_en), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("abort/sr_en", 32'(sr_en), 32'd0);
    check_eq("abort/busy", 32'(busy), 32'd0);
    check_eq("abort/req_ready", 32'(bus.req_ready), 32'd1);
    #2;
    reset = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      saw_valid |= bus.rsp_valid;
      tick();
    end
    check_eq("abort/no_rsp", 32'(saw_valid), 32'd0);

    run_op("post", 4'b0110, 3'd2, 1'b1, 4'b1000, 3, 0, 2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
